// File: rtl/pipelined_adder_nbit_if.sv
// Operand/result stream bundle for pipelined_adder_nbit.
// The master side issues operand beats and sinks results; the slave is the adder.
interface pipelined_adder_nbit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder_nbit.sv
// Sliced-carry adder/subtractor: STAGES register stages, each adding one
// SW-bit slice. Unconsumed operand slices ride in shrinking skew registers,
// finished sum slices accumulate in growing de-skew registers. Valid/ready
// on both sides with bubble collapsing.
module pipelined_adder_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_adder_nbit_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder_nbit: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    logic [STAGES-1:0] vld_pipe;  // per-stage valid
    logic [STAGES:0]   vchain;    // valid offered to each stage (input beat at bit 0)
    logic [STAGES-1:0] rdy;       // stage may take a new beat this cycle
    logic [STAGES-1:0] ld;        // stage actually captures a beat this cycle

    assign vchain = {vld_pipe, bus.in_valid};

    // Ready ripples back from out_ready: a stage is free when empty or draining.
    always_comb begin
        logic r;
        r  = bus.out_ready;
        ld = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = !vld_pipe[k] || r;
            rdy[k] = r;
            ld[k]  = r & vchain[k];
        end
    end

    // Valid bits advance into every stage whose slot is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (rdy[k]) vld_pipe[k] <= vchain[k];
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_pipe[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int AW   = WIDTH - k * SW;   // operand bits not yet added
        localparam int DONE = (k + 1) * SW;     // sum bits complete after this stage

        logic [AW-1:0]   a_in;
        logic [AW-1:0]   b_in;
        logic            c_in;
        logic [SW:0]     slice;
        logic [DONE-1:0] s_d;
        logic [DONE-1:0] s_q;
        logic            c_q;

        if (k == 0) begin : g_src
            // B is inverted on entry so the mode travels with the beat.
            assign a_in = bus.a;
            assign b_in = bus.b ^ {WIDTH{bus.sub}};
            assign c_in = bus.sub | bus.cin;
            assign s_d  = slice[SW-1:0];
        end else begin : g_src
            assign a_in = g_stg[k-1].g_skew.a_q;
            assign b_in = g_stg[k-1].g_skew.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign s_d  = {slice[SW-1:0], g_stg[k-1].s_q};
        end

        assign slice = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

        // Partial sum and inter-slice carry captured only when the stage advances.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (ld[k]) begin
                s_q <= s_d;
                c_q <= slice[SW];
            end
        end

        if (AW > SW) begin : g_skew
            logic [AW-SW-1:0] a_q;
            logic [AW-SW-1:0] b_q;

            // Upper operand slices ride along until their own stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ld[k]) begin
                    a_q <= a_in[AW-1:SW];
                    b_q <= b_in[AW-1:SW];
                end
            end
        end else begin : g_out
            logic ovf_q;

            // Carry into the MSB is recovered as a ^ b ^ s at the top bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ovf_q <= 1'b0;
                else if (ld[k])
                    ovf_q <= slice[SW] ^ (a_in[SW-1] ^ b_in[SW-1] ^ slice[SW-1]);
            end

            assign bus.sum  = s_q;
            assign bus.cout = c_q;
            assign bus.ovf  = ovf_q;
        end
    end
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit: directed scenarios on a (16,4) instance plus
// random traffic on (16,1), (16,16), (8,2). A queue scoreboard holds the
// reference result of every accepted beat.
module tb_pipelined_adder_nbit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // index 0: (16,4)  1: (16,1)  2: (16,16)  3: (8,2)
    logic [3:0]  iv, orr, cin_s, sub_s;
    logic [15:0] ta  [4];
    logic [15:0] tbv [4];
    logic [3:0]  ir, ov, co, of;
    logic [15:0] sm  [4];

    pipelined_adder_nbit_if #(.WIDTH(16)) if0 ();
    pipelined_adder_nbit_if #(.WIDTH(16)) if1 ();
    pipelined_adder_nbit_if #(.WIDTH(16)) if2 ();
    pipelined_adder_nbit_if #(.WIDTH(8))  if3 ();

    pipelined_adder_nbit #(.WIDTH(16), .STAGES(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    pipelined_adder_nbit #(.WIDTH(16), .STAGES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    pipelined_adder_nbit #(.WIDTH(16), .STAGES(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    pipelined_adder_nbit #(.WIDTH(8),  .STAGES(2))  dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.in_valid = iv[0]; assign if0.a = ta[0]; assign if0.b = tbv[0];
    assign if0.cin = cin_s[0]; assign if0.sub = sub_s[0]; assign if0.out_ready = orr[0];
    assign ir[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign sm[0] = if0.sum;
    assign co[0] = if0.cout; assign of[0] = if0.ovf;

    assign if1.in_valid = iv[1]; assign if1.a = ta[1]; assign if1.b = tbv[1];
    assign if1.cin = cin_s[1]; assign if1.sub = sub_s[1]; assign if1.out_ready = orr[1];
    assign ir[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign sm[1] = if1.sum;
    assign co[1] = if1.cout; assign of[1] = if1.ovf;

    assign if2.in_valid = iv[2]; assign if2.a = ta[2]; assign if2.b = tbv[2];
    assign if2.cin = cin_s[2]; assign if2.sub = sub_s[2]; assign if2.out_ready = orr[2];
    assign ir[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign sm[2] = if2.sum;
    assign co[2] = if2.cout; assign of[2] = if2.ovf;

    assign if3.in_valid = iv[3]; assign if3.a = ta[3][7:0]; assign if3.b = tbv[3][7:0];
    assign if3.cin = cin_s[3]; assign if3.sub = sub_s[3]; assign if3.out_ready = orr[3];
    assign ir[3] = if3.in_ready; assign ov[3] = if3.out_valid; assign sm[3] = {8'h00, if3.sum};
    assign co[3] = if3.cout; assign of[3] = if3.ovf;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [17:0] sbq [$];          // {ovf, cout, sum}
    logic        acc, dlv, rdy_s, vld_s;
    logic [17:0] got;

    // Reference: plain integer add, overflow from operand/result sign bits.
    function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
        logic [31:0] mask, xa, ya, tot;
        logic c, v;
        mask = (32'd1 << w) - 32'd1;
        xa   = {16'h0, x} & mask;
        ya   = {16'h0, (s ? ~y : y)} & mask;
        tot  = xa + ya + {31'd0, (s ? 1'b1 : ci)};
        c    = tot[w];
        v    = (xa[w-1] == ya[w-1]) && (tot[w-1] != xa[w-1]);
        return {v, c, tot[15:0] & mask[15:0]};
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock of instance d: sample handshake/outputs at the falling edge,
    // log accepted beats, then step past the next rising edge.
    task automatic tick(input int d);
        @(negedge clk);
        acc   = iv[d] & ir[d];
        dlv   = ov[d] & orr[d];
        rdy_s = ir[d];
        vld_s = ov[d];
        got   = {of[d], co[d], sm[d]};
        if (acc) sbq.push_back(model((d == 3) ? 8 : 16, ta[d], tbv[d], cin_s[d], sub_s[d]));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ov[d] !== 1'b0) begin failures++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", d, ov[d]); end
        end
        checks++;
        if ({of[0], co[0], sm[0]} !== 18'h0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {of[0], co[0], sm[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ir[d] !== 1'b1) begin failures++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", d, ir[d]); end
        end
        sbq.delete();
    endtask

    task automatic test_latency();
        int lat;
        logic [17:0] exp;
        ta[0] = 16'h00FF; tbv[0] = 16'h0001; cin_s[0] = 1'b0; sub_s[0] = 1'b0; orr[0] = 1'b1;
        iv[0] = 1'b1;
        tick(0);
        iv[0] = 1'b0;
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL lat_accept got=%b exp=1", acc); end
        lat = 0;
        dlv = 1'b0;
        while (!dlv && lat < 20) begin tick(0); lat++; end
        checks++;
        if (lat != 4) begin failures++; $display("FAIL lat_cycles got=%0d exp=4", lat); end
        checks++;
        if (got !== 18'h00100) begin failures++; $display("FAIL lat_value got=%h exp=00100", got); end
        if (dlv) begin
            exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("FAIL lat_sb got=%h exp=%h", got, exp); end
        end
    endtask

    task automatic test_flags();
        logic [15:0] av [3] = '{16'hFFFF, 16'h7FFF, 16'h1234};
        logic [15:0] bv [3] = '{16'h0001, 16'h0001, 16'h4321};
        logic        cv [3] = '{1'b0, 1'b0, 1'b1};
        logic [17:0] ev [3] = '{18'h10000, 18'h28000, 18'h05556};
        logic [17:0] exp;
        int n_in = 0, n_out = 0;
        for (int c = 0; c < 40 && n_out < 3; c++) begin
            iv[0] = (n_in < 3);
            if (n_in < 3) begin ta[0] = av[n_in]; tbv[0] = bv[n_in]; cin_s[0] = cv[n_in]; sub_s[0] = 1'b0; end
            tick(0);
            if (acc) n_in++;
            if (dlv) begin
                exp = (sbq.size() != 0) ? sbq.pop_front() : 18'h3FFFF;
                checks++;
                if (got !== exp) begin failures++; $display("FAIL flags_sb got=%h exp=%h", got, exp); end
                checks++;
                if (got !== ev[n_out]) begin failures++; $display("FAIL flags_value%0d got=%h exp=%h", n_out, got, ev[n_out]); end
                n_out++;
            end
        end
        iv[0] = 1'b0;
        checks++;
        if (n_out != 3) begin failures++; $display("FAIL flags_count got=%0d exp=3", n_out); end
    endtask

    task automatic test_subtract();
        logic [15:0] av [4] = '{16'h0005, 16'h0003, 16'h1234, 16'h8000};
        logic [15:0] bv [4] = '{16'h0003, 16'h0005, 16'h4321, 16'h0001};
        logic        cv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        sv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [17:0] ev [4] = '{18'h10002, 18'h0FFFE, 18'h05556, 18'h37FFF};
        logic [17:0] exp;
        int n_in = 0, n_out = 0, last = 0;
        for (int c = 0; c < 40 && n_out < 4; c++) begin
            iv[0] = (n_in < 4);
            if (n_in < 4) begin ta[0] = av[n_in]; tbv[0] = bv[n_in]; cin_s[0] = cv[n_in]; sub_s[0] = sv[n_in]; end
            tick(0);
            if (acc) n_in++;
            if (dlv) begin
                exp = (sbq.size() != 0) ? sbq.pop_front() : 18'h3FFFF;
                checks++;
                if (got !== exp) begin failures++; $display("FAIL sub_sb got=%h exp=%h", got, exp); end
                checks++;
                if (got !== ev[n_out]) begin failures++; $display("FAIL sub_value%0d got=%h exp=%h", n_out, got, ev[n_out]); end
                if (n_out > 0) begin
                    checks++;
                    if (cyc != last + 1) begin failures++; $display("FAIL sub_back_to_back got=%0d exp=%0d", cyc, last + 1); end
                end
                last = cyc;
                n_out++;
            end
        end
        iv[0] = 1'b0;
        checks++;
        if (n_out != 4) begin failures++; $display("FAIL sub_count got=%0d exp=4", n_out); end
    endtask

    task automatic test_backpressure();
        logic [17:0] exp, prev;
        logic        stall_prev = 1'b0;
        int n_in = 0, n_out = 0, full_seen = 0, inflight;
        prev = '0;
        for (int c = 0; c < 60 && n_out < 8; c++) begin
            orr[0] = !(c >= 5 && c <= 7);
            iv[0]  = (n_in < 8);
            ta[0]  = 16'(n_in + 1);
            tbv[0] = 16'(16'h0100 * (n_in + 1));
            cin_s[0] = 1'b0; sub_s[0] = 1'b0;
            tick(0);
            inflight = sbq.size() - int'(acc);
            if (!orr[0] && inflight == 4) begin
                full_seen++;
                checks++;
                if (rdy_s !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b exp=0", rdy_s); end
            end
            if (stall_prev) begin
                checks++;
                if (got !== prev) begin failures++; $display("FAIL bp_hold got=%h exp=%h", got, prev); end
            end
            stall_prev = vld_s && !orr[0];
            prev = got;
            if (acc) n_in++;
            if (dlv) begin
                exp = (sbq.size() != 0) ? sbq.pop_front() : 18'h3FFFF;
                checks++;
                if (got !== exp) begin failures++; $display("FAIL bp_sb got=%h exp=%h", got, exp); end
                checks++;
                if (got !== {2'b00, 16'(16'h0101 * (n_out + 1))}) begin
                    failures++; $display("FAIL bp_order%0d got=%h exp=%h", n_out, got, {2'b00, 16'(16'h0101 * (n_out + 1))});
                end
                n_out++;
            end
        end
        iv[0] = 1'b0; orr[0] = 1'b1;
        checks++;
        if (n_out != 8 || sbq.size() != 0) begin
            failures++; $display("FAIL bp_count got=%0d left=%0d exp=8 left=0", n_out, sbq.size());
        end
        checks++;
        if (full_seen == 0) begin failures++; $display("FAIL bp_full_reached got=0 exp>0"); end
    endtask

    task automatic test_reset_mid();
        logic [17:0] exp;
        int n_out = 0;
        orr[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; ta[0] = 16'(16'h1111 * (i + 1)); tbv[0] = 16'h0101; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
            tick(0);
        end
        iv[0] = 1'b0;
        tick(0);
        checks++;
        if (ov[0] !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b exp=1", ov[0]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0) begin failures++; $display("FAIL rstmid_flush got=%b exp=0", ov[0]); end
        checks++;
        if ({of[0], co[0], sm[0]} !== 18'h0) begin failures++; $display("FAIL rstmid_outputs got=%h exp=0", {of[0], co[0], sm[0]}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sbq.delete();
        for (int i = 0; i < 8; i++) begin
            tick(0);
            checks++;
            if (vld_s !== 1'b0) begin failures++; $display("FAIL rstmid_stale cyc%0d got=%b exp=0", i, vld_s); end
        end
        iv[0] = 1'b1; ta[0] = 16'hAAAA; tbv[0] = 16'h5555; cin_s[0] = 1'b1; sub_s[0] = 1'b0;
        tick(0);
        iv[0] = 1'b0;
        for (int c = 0; c < 20 && n_out < 1; c++) begin
            tick(0);
            if (dlv) begin
                exp = (sbq.size() != 0) ? sbq.pop_front() : 18'h3FFFF;
                checks++;
                if (got !== exp) begin failures++; $display("FAIL rstmid_sb got=%h exp=%h", got, exp); end
                checks++;
                if (got !== 18'h10000) begin failures++; $display("FAIL rstmid_value got=%h exp=10000", got); end
                n_out++;
            end
        end
        checks++;
        if (n_out != 1) begin failures++; $display("FAIL rstmid_recover got=%0d exp=1", n_out); end
    endtask

    task automatic test_sweep(input int d, input int nbeats);
        logic [17:0] exp;
        int n_in = 0, n_out = 0;
        sbq.delete();
        for (int c = 0; c < 4000 && n_out < nbeats; c++) begin
            iv[d]    = (n_in < nbeats) && ($urandom_range(0, 3) != 0);
            ta[d]    = pick_operand();
            tbv[d]   = pick_operand();
            cin_s[d] = 1'($urandom);
            sub_s[d] = 1'($urandom);
            orr[d]   = ($urandom_range(0, 3) != 0);
            tick(d);
            if (acc) n_in++;
            if (dlv) begin
                exp = (sbq.size() != 0) ? sbq.pop_front() : 18'h3FFFF;
                checks++;
                if (got !== exp) begin failures++; $display("FAIL sweep_dut%0d beat%0d got=%h exp=%h", d, n_out, got, exp); end
                n_out++;
            end
        end
        iv[d] = 1'b0; orr[d] = 1'b1;
        checks++;
        if (n_out != nbeats || sbq.size() != 0) begin
            failures++; $display("FAIL sweep_count_dut%0d got=%0d left=%0d exp=%0d", d, n_out, sbq.size(), nbeats);
        end
    endtask

    initial begin
        iv = '0; orr = '1; cin_s = '0; sub_s = '0;
        for (int d = 0; d < 4; d++) begin ta[d] = '0; tbv[d] = '0; end
        test_reset();
        test_latency();
        test_flags();
        test_subtract();
        test_backpressure();
        test_reset_mid();
        for (int d = 0; d < 4; d++) test_sweep(d, 60);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_adder_nbit.md
# pipelined_adder_nbit

Parametrised, pipelined N-bit adder/subtractor, the successor of the team's 4-bit ripple-carry adder. The carry chain is split into STAGES equal slices with a register boundary after each slice, so WIDTH scales without lengthening the critical path. A valid/ready handshake on both sides allows it to sit directly in streaming datapaths. It adds a subtract mode and carry-out and signed-overflow flags.

## Interface
- WIDTH, 16, operand/result width in bits; WIDTH ≥ 1.
- STAGES, 4, number of pipeline slices; 1 ≤ STAGES ≤ WIDTH, and WIDTH % STAGES == 0 (elaboration error otherwise); slice width SW = WIDTH/STAGES.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub = 0.
- sub  in  1  0: A + B + cin; 1: A − B, computed as A + ~B + 1 (cin ignored).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; in sub mode 1 = no borrow.
- ovf  out  1  signed overflow: the carry into the MSB XOR the carry out of the MSB.

## Operation
- Pipeline registers: STAGES stage registers S0..S(STAGES−1), each holding valid, partial sum, the carry between slices, and any unprocessed operand slices.
- Stage k adds slice k, bits [k·SW +: SW], using the carry registered by stage k−1 (stage 0 uses cin, or 1 when sub = 1).
- Operand slices not yet consumed are carried forward in skew registers.
- Completed lower sum slices are carried forward in de-skew registers.
- B is inverted on entry when sub = 1, so the mode travels with the data. Beats with different sub values may be interleaved freely.
- The final stage drives sum, cout and ovf. The carry into the MSB is taken inside the final slice.
- Handshake:
  - A beat is accepted when in_valid and in_ready are both 1.
  - A result is delivered when out_valid and out_ready are both 1.
- Stall (bubble-collapsing):
  - Define ready_k = !valid_k || ready_(k+1), with ready_STAGES = out_ready.
  - Stage k loads from stage k−1 when ready_k = 1.
  - in_ready = ready_0. in_ready is combinational from out_ready and the valid bits; no path runs from in_valid to in_ready.
- Output stability: while out_valid = 1 and out_ready = 0, sum, cout and ovf are held constant.
- Ordering: results leave in acceptance order. Beats are never dropped or duplicated.
- Capacity: STAGES beats in flight. When all stages are valid and out_ready = 0, in_ready = 0.
- Data registers load only when their stage advances. Their contents are don't-care while the stage's valid bit is 0.

## Timing
- Reset (asynchronous assert; release synchronous to clk):
  - All valid bits clear to 0, so out_valid = 0.
  - sum = 0, cout = 0, ovf = 0.
  - in_ready = 1 in the first cycle after release.
- Reset asserted mid-operation flushes every in-flight beat immediately. No partial result is emitted afterwards.
- Latency: a beat accepted at edge N gives out_valid = 1 after edge N+STAGES − 1, i.e. the result is present during the cycle following edge N+STAGES − 1. This holds when there is no stall. With STAGES = 1 the result is visible in the cycle after acceptance.
- Throughput: one beat per cycle while out_ready = 1.
- Simultaneous accept and deliver while full: allowed. With out_ready = 1 the chain is ready, so accept and deliver happen in the same cycle.
- Carry wrap: 0xFFFF + 1 gives sum 0 and cout 1. No saturation.

## Test plan
(WIDTH = 16, STAGES = 4 unless stated.)
- Latency and basic add: reset, then a = 0x00FF, b = 0x0001, cin = 0, sub = 0, out_ready = 1. Required: sum = 0x0100, cout = 0, ovf = 0, with out_valid appearing exactly 4 cycles after acceptance. Also, in_ready = 1 right after reset.
- Carry, wrap and overflow flags:
  - 0xFFFF + 0x0001 gives sum 0x0000, cout 1, ovf 0.
  - 0x7FFF + 0x0001 gives sum 0x8000, cout 0, ovf 1.
  - 0x1234 + 0x4321 with cin = 1 gives sum 0x5556.
- Subtract with interleaved modes, issued back-to-back:
  - 0x0005 − 0x0003 gives 0x0002, cout 1.
  - 0x0003 − 0x0005 gives 0xFFFE, cout 0.
  - 0x8000 − 0x0001 gives 0x7FFF, ovf 1.
  - Required: the three results appear on consecutive cycles in that order.
- Backpressure: stream 8 beats (a = i, b = 0x0100·i) with out_ready held low for cycles 5–7. Required:
  - in_ready = 0 once 4 beats are held.
  - Outputs are stable during the stall.
  - All 8 results are delivered in order, with none lost or duplicated.
- Reset mid-stream: assert rst_n = 0 while 3 beats are in flight. Required: out_valid = 0 at once and no stale results after release.
- Parameter sweep: run random add/sub traffic with random out_ready at (WIDTH, STAGES) = (16, 1), (16, 16) and (8, 2). Required: results match a + (sub ? ~b + 1 : b + cin) modulo 2^WIDTH, including cout and ovf.
